// File: rtl/mul_nibble_seq_pkg.sv
// ============================================================================
// Package : mul_seq_pkg
// Shared types and constants for the nibble-serial multiplier:
//   - state_t     : controller states (IDLE, MUL, DONE)
//   - NIB_W       : nibble width processed per cycle
//   - nib_count() : nibbles per operand for a given operand width
//   - prod_count(): nibble products needed for a given operand width
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int opw);
    return opw / NIB_W;
  endfunction

  // Every nibble of a is paired with every nibble of b.
  function automatic int prod_count(input int opw);
    return nib_count(opw) * nib_count(opw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_nibble_seq_if.sv
// ============================================================================
// Interface : mul_nibble_seq_if
// Request/response bundle of the nibble-serial multiplier.
//   req_valid/req_ready   : request handshake
//   req_a/req_b           : operands (OPW bits)
//   req_signed            : two's-complement request
//   rsp_valid/rsp_ready   : response handshake
//   rsp_p                 : product (2*OPW bits)
//   busy                  : block is not idle
// Modports: master (requester/consumer), slave (multiplier).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_nibble_seq_if #(
  parameter int OPW = 16
);
  logic               req_valid;
  logic               req_ready;
  logic [OPW-1:0]     req_a;
  logic [OPW-1:0]     req_b;
  logic               req_signed;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*OPW-1:0]   rsp_p;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_p, busy
  );
endinterface

`default_nettype wire

// File: rtl/mul_nibble_seq_wallace4.sv
// ============================================================================
// Module : wallace4
// 4x4 unsigned multiplier: four partial-product rows reduced by two
// carry-save stages, then one final carry-propagate add.
//   i_a, i_b : 4-bit operands
//   o_p      : 8-bit product
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace4 (
  input  wire logic [3:0] i_a,
  input  wire logic [3:0] i_b,
  output logic      [7:0] o_p
);
  logic [7:0] w_pp0, w_pp1, w_pp2, w_pp3;
  logic [7:0] w_s1, w_c1, w_s2, w_c2;

  assign w_pp0 = {4'b0000, i_a & {4{i_b[0]}}};
  assign w_pp1 = {3'b000,  i_a & {4{i_b[1]}}, 1'b0};
  assign w_pp2 = {2'b00,   i_a & {4{i_b[2]}}, 2'b00};
  assign w_pp3 = {1'b0,    i_a & {4{i_b[3]}}, 3'b000};

  // Truncation to 8 bits is safe: the full product never exceeds 8 bits.
  assign w_s1 = w_pp0 ^ w_pp1 ^ w_pp2;
  assign w_c1 = ((w_pp0 & w_pp1) | (w_pp0 & w_pp2) | (w_pp1 & w_pp2)) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp3;
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp3) | (w_c1 & w_pp3)) << 1;
  assign o_p  = w_s2 + w_c2;
endmodule

`default_nettype wire

// File: rtl/mul_nibble_seq.sv
// ============================================================================
// Module : mul_nibble_seq
// Sequential multiplier computing one 4x4 nibble product per cycle with a
// single shared wallace4 instance; (OPW/4)^2 cycles per operation.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : mul_nibble_seq_if.slave (request/response handshake, busy)
// Optional feature: define MUL_NIBBLE_SEQ_SIGNED_EN to honour req_signed
// (sign-magnitude operation, result negated when operand signs differ).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_nibble_seq
  import mul_seq_pkg::*;
#(
  parameter int OPW = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mul_nibble_seq_if.slave bus
);
  localparam int N  = nib_count(OPW);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * OPW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          r_state;
  logic [OPW-1:0]  r_a, r_b;
  logic [PW-1:0]   r_acc, r_p;
  logic [IW-1:0]   r_i, r_j;
  logic            r_neg;

  logic [OPW-1:0]  w_mag_a, w_mag_b;
  logic            w_neg;
  logic [IW+1:0]   w_lsb_a, w_lsb_b;
  logic [3:0]      w_nib_a, w_nib_b;
  logic [7:0]      w_prod;
  logic [IW:0]     w_ij;
  logic [IW+2:0]   w_sh;
  logic [PW-1:0]   w_term, w_sum, w_final;

`ifdef MUL_NIBBLE_SEQ_SIGNED_EN
  logic w_sa, w_sb;
  assign w_sa    = bus.req_signed & bus.req_a[OPW-1];
  assign w_sb    = bus.req_signed & bus.req_b[OPW-1];
  // -2^(OPW-1) negates to itself, which read unsigned is the right magnitude.
  assign w_mag_a = w_sa ? -bus.req_a : bus.req_a;
  assign w_mag_b = w_sb ? -bus.req_b : bus.req_b;
  assign w_neg   = w_sa ^ w_sb;
`else
  logic w_unused_signed;
  assign w_unused_signed = bus.req_signed;
  assign w_mag_a = bus.req_a;
  assign w_mag_b = bus.req_b;
  assign w_neg   = 1'b0;
`endif

  assign w_lsb_a = {r_i, 2'b00};
  assign w_lsb_b = {r_j, 2'b00};
  assign w_nib_a = r_a[w_lsb_a +: NIB_W];
  assign w_nib_b = r_b[w_lsb_b +: NIB_W];

  wallace4 u_wallace4 (
    .i_a (w_nib_a),
    .i_b (w_nib_b),
    .o_p (w_prod)
  );

  // Partial product weight is 16^(i+j), i.e. a left shift by 4*(i+j).
  assign w_ij    = {1'b0, r_i} + {1'b0, r_j};
  assign w_sh    = {w_ij, 2'b00};
  assign w_term  = {{(PW-8){1'b0}}, w_prod} << w_sh;
  assign w_sum   = r_acc + w_term;
  assign w_final = r_neg ? -w_sum : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc <= w_sum;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              // Final product is captured here so rsp_p is stable in DONE
              // and keeps its value once back in IDLE.
              r_i     <= '0;
              r_p     <= w_final;
              r_state <= DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_p     = r_p;
endmodule

`default_nettype wire

// File: tb/tb_mul_nibble_seq.sv
// ============================================================================
// Module : tb_mul_nibble_seq
// Self-checking bench for mul_nibble_seq (OPW=16): directed vectors, reset
// abort, signed handling and randomized operations against an arithmetic
// reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_nibble_seq;
  import mul_seq_pkg::*;

  localparam int OPW = 16;
  localparam int LAT = prod_count(OPW) + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  mul_nibble_seq_if #(.OPW(OPW)) bus ();

  mul_nibble_seq #(.OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Mathematical product, truncated to 2*OPW bits.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    longint pa, pb;
    pa = longint'(a);
    pb = longint'(b);
`ifdef MUL_NIBBLE_SEQ_SIGNED_EN
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end
`else
    if (s) pa = longint'(a);
`endif
    return 32'(pa * pb);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int hold, input logic [31:0] exp);
    int t;
    int first;
    logic [31:0] held;
    @(negedge clk);
    check({tag, " ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_signed = s;
    t = cyc;
    @(posedge clk);
    #1;
    // Scramble inputs while busy; they must not affect the result.
    bus.req_valid  = 1'b0;
    bus.req_a      = 16'($urandom);
    bus.req_b      = 16'($urandom);
    bus.req_signed = 1'($urandom);
    first = -1;
    for (int k = 0; k < 60 && first < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) first = cyc;
    end
    check({tag, " latency"}, 64'(first), 64'(t + LAT));
    check({tag, " product"}, 64'(bus.rsp_p), 64'(exp));
    held = bus.rsp_p;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold_p"}, 64'(bus.rsp_p), 64'(held));
      check({tag, " hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      check({tag, " hold_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    check({tag, " hs_ready"}, 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, " post_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, " post_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, " post_p"}, 64'(bus.rsp_p), 64'(held));
  endtask

  initial begin
    int t;
    logic seen;
    logic [15:0] ra, rb;
    logic rs;
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_signed = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", 64'(bus.req_ready), 64'd1);
    check("reset valid", 64'(bus.rsp_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset p", 64'(bus.rsp_p), 64'd0);
    rst_n = 1'b1;

    run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001);
    run_op("zero_a", 16'h0000, 16'h1234, 1'b0, 0, 32'h00000000);
    run_op("stall", 16'h1234, 16'h5678, 1'b0, 5, 32'h06260060);

    // Reset in the middle of an operation: no response may follow.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'hABCD;
    bus.req_b     = 16'h1357;
    t = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    while (cyc < t + 8) @(negedge clk);
    check("abort busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort valid", 64'(bus.rsp_valid), 64'd0);
    check("abort p", 64'(bus.rsp_p), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("abort no_rsp", 64'(seen), 64'd0);
    check("abort ready", 64'(bus.req_ready), 64'd1);

`ifdef MUL_NIBBLE_SEQ_SIGNED_EN
    run_op("signed_m1", 16'hFFFF, 16'h0001, 1'b1, 0, 32'hFFFFFFFF);
`else
    run_op("signed_m1", 16'hFFFF, 16'h0001, 1'b1, 0, 32'h0000FFFF);
`endif
    run_op("min_min", 16'h8000, 16'h8000, 1'b1, 1, 32'h40000000);

    for (int n = 0; n < 10; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op("random", ra, rb, rs, int'($urandom_range(0, 2)), model(ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
